// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared types and defaults for the MIPS pipeline stage registers.
//   ex_mem_ctrl_t : MEM/WB control bundle carried from EX into MEM,
//                   bit order {mem_to_reg, mem_read, mem_write, bw, reg_write}
//   CTRL_NOP      : all-zero control word used for bubbles
//   occ_state_e   : occupancy of a two-entry skid buffer
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    typedef struct packed {
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic bw;
        logic reg_write;
    } ex_mem_ctrl_t;

    localparam int CTRL_W_DEF = $bits(ex_mem_ctrl_t);

    // A bubble carries no write enables of any kind.
    localparam ex_mem_ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic W-bit, two-entry skid buffer with valid/ready on both sides and a
// flush that squashes everything held plus the entry presented that cycle.
// The main register drives the output; the skid register catches the one
// entry that arrives while the output is stalled. in_ready is decoded from
// registered state only, so there is no combinational path from out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash held and incoming entries
//   in_valid/in_ready   upstream handshake
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        payload held in the main register
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         do_accept;
    logic         do_release;

    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;

    assign do_accept  = in_valid & in_ready;
    assign do_release = out_valid & out_ready;

    // Next-state/data selection. Flush wins over everything; held data is
    // left in place because it is don't-care once the valid is dropped.
    // In FULL the skid entry is always the younger one, so it only ever
    // moves into main after main has been released.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (do_accept) begin
                        main_d  = in_data;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (do_accept && do_release) begin
                        main_d = in_data;
                    end else if (do_accept) begin
                        skid_d  = in_data;
                        state_d = OCC_FULL;
                    end else if (do_release) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (do_release) begin
                        main_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
// EX->MEM pipeline register with valid/ready back-pressure, a two-entry skid
// buffer and flush. Carries ALU result, store data, destination register and
// the MEM/WB control bundle. Control is forced to CTRL_NOP whenever the
// output is not valid so a bubble can never write a register or memory.
// Optional build macro: EX_MEM_PERF_EN adds saturating stall/flush counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash held and incoming entries
//   in_valid/in_ready        EX-side handshake (in_ready is registered)
//   in_alu, in_st_data       ALU result / address and store data [XLEN]
//   in_rdest [RA_W]          destination register
//   in_ctrl [CTRL_W]         {mem_to_reg, mem_read, mem_write, bw, reg_write}
//   out_valid/out_ready      MEM-side handshake
//   out_alu, out_st_data, out_rdest, out_ctrl   held entry
//   stall_cnt [CNT_W]        (EX_MEM_PERF_EN) cycles with out_valid & !out_ready
//   flush_cnt [CNT_W]        (EX_MEM_PERF_EN) flushes that killed a valid entry
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage
    import mips_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef EX_MEM_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_st_data,
    input  logic [RA_W-1:0]   in_rdest,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_st_data,
    output logic [RA_W-1:0]   out_rdest,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef EX_MEM_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int BUS_W = 2 * XLEN + RA_W + CTRL_W;

    logic [BUS_W-1:0]  in_bus;
    logic [BUS_W-1:0]  out_bus;
    logic [CTRL_W-1:0] held_ctrl;

    assign in_bus = {in_alu, in_st_data, in_rdest, in_ctrl};

    pipe_skid_buf #(
        .W(BUS_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_bus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_bus)
    );

    assign {out_alu, out_st_data, out_rdest, held_ctrl} = out_bus;

    // Data fields may show stale values during a bubble; only control is
    // masked because it alone can cause side effects downstream.
    assign out_ctrl = out_valid ? held_ctrl : CTRL_W'(CTRL_NOP);

`ifdef EX_MEM_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             flush_kills;

    // A flush only counts when it actually destroys work: something held,
    // or an entry being accepted in the same cycle.
    assign flush_kills = flush & (out_valid | (in_valid & in_ready));

    // Both counters saturate instead of wrapping so a long run never reads
    // back as a small number.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_kills && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
// Directed bench for ex_mem_pipe_stage. The driver pushes each entry it
// expects the stage to accept into a queue; a negedge monitor compares the
// presented output against the queue head and pops it on release.
// Optional build macro: EX_MEM_PERF_EN (counters checked with CNT_W=4).
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;
    import mips_pipe_pkg::*;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 5;
`ifdef EX_MEM_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_alu;
    logic [XLEN-1:0]   in_st_data;
    logic [RA_W-1:0]   in_rdest;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_alu;
    logic [XLEN-1:0]   out_st_data;
    logic [RA_W-1:0]   out_rdest;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   st;
        logic [RA_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(
        .XLEN  (XLEN),
        .RA_W  (RA_W),
        .CTRL_W(CTRL_W)
`ifdef EX_MEM_PERF_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu     (in_alu),
        .in_st_data (in_st_data),
        .in_rdest   (in_rdest),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu    (out_alu),
        .out_st_data(out_st_data),
        .out_rdest  (out_rdest),
        .out_ctrl   (out_ctrl)
`ifdef EX_MEM_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic checkState(input string name, input logic exp_valid, input logic exp_ready);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'(exp_valid));
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
        if (!exp_valid) begin
            checkOutput({name, "_out_ctrl"}, 32'(out_ctrl), 32'd0);
        end
    endtask

    // Drives one cycle of inputs (store data is ~alu), records the entry as
    // expected when the scenario says it gets accepted, and clears the
    // expectation queue on flush. Returns 1 time unit after the posedge.
    task automatic applyStimulus(input logic v, input logic [XLEN-1:0] alu, input logic [RA_W-1:0] rd,
                                 input logic [CTRL_W-1:0] ctrl, input logic ordy, input logic fl,
                                 input logic push);
        exp_t e;
        in_valid   = v;
        in_alu     = alu;
        in_st_data = ~alu;
        in_rdest   = rd;
        in_ctrl    = ctrl;
        out_ready  = ordy;
        flush      = fl;
        if (fl) exp_q.delete();
        if (push) begin
            e.alu  = alu;
            e.st   = ~alu;
            e.rd   = rd;
            e.ctrl = ctrl;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_alu     = 32'hDEAD_BEEF;
        in_st_data = 32'hCAFE_F00D;
        in_rdest   = 5'd31;
        in_ctrl    = 5'b11111;
        out_ready  = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Monitor: every presented entry must match the queue head and stay put
    // until released; a bubble must never carry control bits.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) begin
                checkOutput("bubble_ctrl", 32'(out_ctrl), 32'd0);
            end else if (!flush) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_entry_valid", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("entry_alu", out_alu, exp_q[0].alu);
                    checkOutput("entry_st_data", out_st_data, exp_q[0].st);
                    checkOutput("entry_rdest", 32'(out_rdest), 32'(exp_q[0].rd));
                    checkOutput("entry_ctrl", 32'(out_ctrl), 32'(exp_q[0].ctrl));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset with in_valid held high: nothing may be captured.
        doReset();
        checkState("reset", 1'b0, 1'b1);
        checkOutput("reset_out_alu", out_alu, 32'd0);
        checkOutput("reset_out_rdest", 32'(out_rdest), 32'd0);
`ifdef EX_MEM_PERF_EN
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

        // Streaming: one entry per cycle, no gaps.
        applyStimulus(1'b1, 32'h10, 5'd1, 5'b00001, 1'b1, 1'b0, 1'b1);
        checkState("stream0", 1'b1, 1'b1);
        checkOutput("stream0_alu", out_alu, 32'h10);
        applyStimulus(1'b1, 32'h20, 5'd2, 5'b10011, 1'b1, 1'b0, 1'b1);
        checkState("stream1", 1'b1, 1'b1);
        checkOutput("stream1_alu", out_alu, 32'h20);
        applyStimulus(1'b1, 32'h30, 5'd3, 5'b00100, 1'b1, 1'b0, 1'b1);
        checkState("stream2", 1'b1, 1'b1);
        checkOutput("stream2_alu", out_alu, 32'h30);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkState("stream_end", 1'b0, 1'b1);

        // Back-pressure: A then B fill the stage, C is refused while FULL.
        applyStimulus(1'b1, 32'h11, 5'd4, 5'b00101, 1'b0, 1'b0, 1'b1);
        checkState("bp_a", 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h22, 5'd5, 5'b01001, 1'b0, 1'b0, 1'b1);
        checkState("bp_full", 1'b1, 1'b0);
        checkOutput("bp_hold_a", out_alu, 32'h11);
        applyStimulus(1'b1, 32'h33, 5'd6, 5'b00001, 1'b0, 1'b0, 1'b0);
        checkState("bp_refuse", 1'b1, 1'b0);
        checkOutput("bp_still_a", out_alu, 32'h11);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkState("bp_drain_a", 1'b1, 1'b1);
        checkOutput("bp_then_b", out_alu, 32'h22);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkState("bp_drain_b", 1'b0, 1'b1);

        // Flush while FULL with a third entry presented: all three vanish.
        applyStimulus(1'b1, 32'h44, 5'd7, 5'b00011, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h55, 5'd8, 5'b00101, 1'b0, 1'b0, 1'b1);
        checkState("fl_full", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h66, 5'd9, 5'b11111, 1'b0, 1'b1, 1'b0);
        checkState("fl_after", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
            checkState("fl_quiet", 1'b0, 1'b1);
        end

        // Flush beats a simultaneous release.
        applyStimulus(1'b1, 32'h77, 5'd10, 5'b00001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b1, 1'b0);
        checkState("fl_vs_release", 1'b0, 1'b1);

        // Bubbles with all control bits asserted on the input side.
        applyStimulus(1'b1, 32'h88, 5'd11, 5'b11111, 1'b1, 1'b0, 1'b1);
        checkOutput("bubble_pre_ctrl", 32'(out_ctrl), 32'h1F);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h99, 5'd12, 5'b11111, 1'b1, 1'b0, 1'b0);
            checkState("bubble", 1'b0, 1'b1);
        end

`ifdef EX_MEM_PERF_EN
        // Counters: 20 stall cycles saturate at 15; a flush that kills an
        // entry counts, a flush of an empty stage does not.
        doReset();
        applyStimulus(1'b1, 32'hA0, 5'd13, 5'b00001, 1'b0, 1'b0, 1'b1);
        checkOutput("perf_stall_0", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_stall_5", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_stall_sat", 32'(stall_cnt), 32'd15);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b0, 1'b1, 1'b0);
        checkOutput("perf_flush_kill", 32'(flush_cnt), 32'd1);
        checkOutput("perf_stall_hold", 32'(stall_cnt), 32'd15);
        applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b0, 1'b1, 1'b0);
        checkOutput("perf_flush_empty", 32'(flush_cnt), 32'd1);
`endif

        // Everything that was expected must have come out.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 5'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("leftover_entries", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
